multi_vend_ctrl: RTL and testbench

MULTI_VEND_CTRL -- requirements
Module: multi_vend_ctrl

---
 rtl/multi_vend_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multi_vend_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multi_vend_ctrl.sv
// Multi-product vending controller.
// Accepts Re.1 / Rs.2 coins up to a credit ceiling, vends one of NUM_PROD
// products against a per-product price table, and pays back any remaining
// credit one coin per cycle (largest coin first). Every output is registered.
module multi_vend_ctrl #(
    parameter int NUM_PROD = 4,
    parameter int SEL_W = 2,
    parameter int PRICE_W = 4,
    parameter logic [NUM_PROD*PRICE_W-1:0] PRICES = {4'd6, 4'd5, 4'd4, 4'd3},
    parameter int CREDIT_W = 4,
    parameter int MAX_CREDIT = 9
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [1:0]          coin,
    input  logic                buy,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    output logic                dispense,
    output logic [SEL_W-1:0]    prod_id,
    output logic                ret_one,
    output logic                ret_two,
    output logic                coin_rej,
    output logic                short_fund,
    output logic                busy,
    output logic [CREDIT_W-1:0] credit
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    state_t state_r;

    logic [1:0]          coin_val_s;
    logic                coin_present_s;
    logic [CREDIT_W:0]   coin_sum_s;
    logic                coin_fits_s;
    logic [PRICE_W-1:0]  price_s;
    logic                sel_ok_s;
    logic                afford_s;

    // Price table lookup; an out-of-range index yields 0 and is rejected by sel_ok_s.
    function automatic logic [PRICE_W-1:0] price_of(input logic [SEL_W-1:0] s);
        logic [PRICE_W-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_PROD; i++) begin
            if (int'(s) == i) begin
                p = PRICES[i*PRICE_W +: PRICE_W];
            end
        end
        return p;
    endfunction

    // Decode the coin sensor and evaluate the affordability of the selected product.
    always_comb begin
        coin_val_s     = 2'd0;
        coin_present_s = 1'b0;
        if (coin[1]) begin
            coin_present_s = 1'b1;
            if (coin[0]) begin
                coin_val_s = 2'd2;
            end else begin
                coin_val_s = 2'd1;
            end
        end else begin
            coin_present_s = 1'b0;
            coin_val_s     = 2'd0;
        end
        // The add is done one bit wider so an overflow can never wrap past the ceiling.
        coin_sum_s  = (CREDIT_W+1)'(credit) + (CREDIT_W+1)'(coin_val_s);
        coin_fits_s = (int'(coin_sum_s) <= MAX_CREDIT);
        price_s     = price_of(sel);
        sel_ok_s    = (int'(sel) < NUM_PROD);
        afford_s    = (int'(credit) >= int'(price_s));
    end

    // Main controller: state, credit and all registered pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            credit     <= '0;
            dispense   <= 1'b0;
            prod_id    <= '0;
            ret_one    <= 1'b0;
            ret_two    <= 1'b0;
            coin_rej   <= 1'b0;
            short_fund <= 1'b0;
            busy       <= 1'b0;
        end else begin
            dispense   <= 1'b0;
            prod_id    <= '0;
            ret_one    <= 1'b0;
            ret_two    <= 1'b0;
            coin_rej   <= 1'b0;
            short_fund <= 1'b0;
            case (state_r)
                IDLE, COLLECT: begin
                    if (cancel && (state_r == COLLECT)) begin
                        // Refund everything; any coin on the same edge goes back too.
                        state_r  <= CHANGE;
                        busy     <= 1'b1;
                        coin_rej <= coin_present_s;
                    end else if (buy) begin
                        // Buy is judged on the credit held before this edge.
                        coin_rej <= coin_present_s;
                        if ((state_r == COLLECT) && sel_ok_s && afford_s) begin
                            credit   <= credit - CREDIT_W'(price_s);
                            state_r  <= VEND;
                            busy     <= 1'b1;
                            dispense <= 1'b1;
                            prod_id  <= sel;
                        end else begin
                            short_fund <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end else if (coin_present_s) begin
                        busy <= 1'b0;
                        // A cancel ignored in IDLE still bars the coin on that edge.
                        if (coin_fits_s && !cancel) begin
                            credit  <= coin_sum_s[CREDIT_W-1:0];
                            state_r <= COLLECT;
                        end else begin
                            coin_rej <= 1'b1;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                VEND: begin
                    coin_rej   <= coin_present_s;
                    short_fund <= buy;
                    if (credit != '0) begin
                        state_r <= CHANGE;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                CHANGE: begin
                    coin_rej   <= coin_present_s;
                    short_fund <= buy;
                    if (int'(credit) >= 2) begin
                        ret_two <= 1'b1;
                        credit  <= credit - CREDIT_W'(2);
                        if (int'(credit) == 2) begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            busy    <= 1'b1;
                        end
                    end else if (credit == CREDIT_W'(1)) begin
                        ret_one <= 1'b1;
                        credit  <= '0;
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end else begin
                        // Nothing left to pay back.
                        state_r <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    credit  <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_vend_ctrl.sv
// Directed self-checking bench for multi_vend_ctrl (default parameters:
// prices p0=3 p1=4 p2=5 p3=6, MAX_CREDIT=9).
// Expected pulse vector order: {dispense, ret_one, ret_two, coin_rej, short_fund, busy}.
module tb_multi_vend_ctrl;

    logic       clock;
    logic       reset;
    logic [1:0] coin;
    logic       buy;
    logic [1:0] sel;
    logic       cancel;
    logic       dispense;
    logic [1:0] prod_id;
    logic       ret_one;
    logic       ret_two;
    logic       coin_rej;
    logic       short_fund;
    logic       busy;
    logic [3:0] credit;

    int errors = 0;
    int checks = 0;

    localparam logic [1:0] C0 = 2'b00;
    localparam logic [1:0] C1 = 2'b10;
    localparam logic [1:0] C2 = 2'b11;

    multi_vend_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .coin       (coin),
        .buy        (buy),
        .sel        (sel),
        .cancel     (cancel),
        .dispense   (dispense),
        .prod_id    (prod_id),
        .ret_one    (ret_one),
        .ret_two    (ret_two),
        .coin_rej   (coin_rej),
        .short_fund (short_fund),
        .busy       (busy),
        .credit     (credit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [5:0] p,
                              input logic [3:0] cr, input logic [1:0] pid);
        chk({tag, ".pulses"}, 32'({dispense, ret_one, ret_two, coin_rej, short_fund, busy}), 32'(p));
        chk({tag, ".credit"}, 32'(credit), 32'(cr));
        chk({tag, ".prod_id"}, 32'(prod_id), 32'(pid));
        chk({tag, ".ret_excl"}, 32'(ret_one & ret_two), 32'd0);
    endtask

    // Apply one cycle of inputs, let the edge happen, sample 1 time unit later.
    task automatic step(input logic [1:0] c, input logic b, input logic [1:0] s, input logic x);
        coin   = c;
        buy    = b;
        sel    = s;
        cancel = x;
        @(posedge clock);
        #1;
        coin   = C0;
        buy    = 1'b0;
        cancel = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        coin   = C0;
        buy    = 1'b0;
        sel    = 2'd0;
        cancel = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        expect_out("reset", 6'b000000, 4'd0, 2'd0);
        reset = 1'b0;

        // Coin 1 then 2, buy product 0 (price 3): exact, no change.
        step(C1, 1'b0, 2'd0, 1'b0);  expect_out("a.coin1", 6'b000000, 4'd1, 2'd0);
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("a.coin2", 6'b000000, 4'd3, 2'd0);
        step(C0, 1'b1, 2'd0, 1'b0);  expect_out("a.buy", 6'b100001, 4'd0, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("a.idle", 6'b000000, 4'd0, 2'd0);

        // Buy with no credit.
        step(C0, 1'b1, 2'd0, 1'b0);  expect_out("idle.buy", 6'b000010, 4'd0, 2'd0);

        // 2+2, buy p0 -> one Re.1 back.
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("b.coin1", 6'b000000, 4'd2, 2'd0);
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("b.coin2", 6'b000000, 4'd4, 2'd0);
        step(C0, 1'b1, 2'd0, 1'b0);  expect_out("b.buy", 6'b100001, 4'd1, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("b.vend", 6'b000001, 4'd1, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("b.ret1", 6'b010000, 4'd0, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("b.idle", 6'b000000, 4'd0, 2'd0);

        // 2+2+2, buy p3 (price 6): exact.
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("c.coins", 6'b000000, 4'd6, 2'd0);
        step(C0, 1'b1, 2'd3, 1'b0);  expect_out("c.buy", 6'b100001, 4'd0, 2'd3);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("c.idle", 6'b000000, 4'd0, 2'd0);

        // 2+2+2+1 then cancel: three Rs.2, one Re.1.
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C1, 1'b0, 2'd0, 1'b0);  expect_out("d.coins", 6'b000000, 4'd7, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b1);  expect_out("d.cancel", 6'b000001, 4'd7, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("d.ret2a", 6'b001001, 4'd5, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("d.ret2b", 6'b001001, 4'd3, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("d.ret2c", 6'b001001, 4'd1, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("d.ret1", 6'b010000, 4'd0, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("d.idle", 6'b000000, 4'd0, 2'd0);

        // Credit 2, buy p1 (price 4): refused.
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("e.coin", 6'b000000, 4'd2, 2'd0);
        step(C0, 1'b1, 2'd1, 1'b0);  expect_out("e.short", 6'b000010, 4'd2, 2'd0);
        // Climb to 8, coin 2 overflows, coin 1 reaches 9, coin 1 overflows.
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("e.eight", 6'b000000, 4'd8, 2'd0);
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("e.rej2", 6'b000100, 4'd8, 2'd0);
        step(C1, 1'b0, 2'd0, 1'b0);  expect_out("e.nine", 6'b000000, 4'd9, 2'd0);
        step(C1, 1'b0, 2'd0, 1'b0);  expect_out("e.rej1", 6'b000100, 4'd9, 2'd0);

        // Coin with buy p2 (price 5) at credit 9: coin refused, buy on prior credit.
        step(C1, 1'b1, 2'd2, 1'b0);  expect_out("f.buycoin", 6'b100101, 4'd4, 2'd2);
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("f.vendcoin", 6'b000101, 4'd4, 2'd0);
        step(C2, 1'b0, 2'd0, 1'b0);  expect_out("f.chgcoin", 6'b001101, 4'd2, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("f.ret2", 6'b001000, 4'd0, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("f.idle", 6'b000000, 4'd0, 2'd0);

        // Reset on the second CHANGE cycle forfeits the rest.
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C2, 1'b0, 2'd0, 1'b0);
        step(C1, 1'b0, 2'd0, 1'b0);  expect_out("g.coins", 6'b000000, 4'd5, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b1);  expect_out("g.cancel", 6'b000001, 4'd5, 2'd0);
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("g.ret2", 6'b001001, 4'd3, 2'd0);
        reset = 1'b1;
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("g.reset", 6'b000000, 4'd0, 2'd0);
        reset = 1'b0;
        step(C0, 1'b0, 2'd0, 1'b0);  expect_out("g.quiet", 6'b000000, 4'd0, 2'd0);
        step(C1, 1'b0, 2'd0, 1'b0);  expect_out("g.coin", 6'b000000, 4'd1, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
